// File: rtl/arcade_coin_pkg.sv
// Shared types and default timing for the arcade coin conditioner.
package arcade_coin_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } coin_state_e;

    localparam int unsigned DEF_DEB_CYCLES   = 48000;
    localparam int unsigned DEF_PULSE_FRAMES = 3;
    localparam int unsigned DEF_GAP_FRAMES   = 3;
    localparam int unsigned DEF_MAX_PENDING  = 7;
    localparam int unsigned FCNT_W           = 4;

    function automatic int unsigned pend_width(input int unsigned max_pending);
        return $clog2(max_pending + 1);
    endfunction

    localparam int unsigned DEF_PW = pend_width(DEF_MAX_PENDING);

endpackage

// File: rtl/arcade_coin_conditioner_if.sv
// Coin request inputs, frame timing and conditioned coin/status outputs.
interface arcade_coin_conditioner_if #(
    parameter int unsigned PW = arcade_coin_pkg::DEF_PW
);
    logic [1:0]    coin_in;
    logic          vblank;
    logic          coin_out;
    logic          busy;
    logic [PW-1:0] pending0;
    logic [PW-1:0] pending1;

    modport master (
        output coin_in, vblank,
        input  coin_out, busy, pending0, pending1
    );

    modport slave (
        input  coin_in, vblank,
        output coin_out, busy, pending0, pending1
    );
endinterface

// File: rtl/coin_debounce.sv
// One coin channel: 2-FF synchroniser, stability debounce, accepted-press pulse.
module coin_debounce
    import arcade_coin_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic raw,
    output logic rise
);
    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          deb_q;

    // Level is accepted only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            rise   <= 1'b0;
            if (sync_q[1] == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                cnt_q <= '0;
                deb_q <= sync_q[1];
                rise  <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/arcade_coin_conditioner.sv
// Debounces two coin sources, queues credits per channel and replays them as
// frame-aligned fixed-width pulses on a single coin line, round-robin between channels.
module arcade_coin_conditioner
    import arcade_coin_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int unsigned PULSE_FRAMES = DEF_PULSE_FRAMES,
    parameter int unsigned GAP_FRAMES   = DEF_GAP_FRAMES,
    parameter int unsigned MAX_PENDING  = DEF_MAX_PENDING
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    arcade_coin_conditioner_if.slave  bus
);
    localparam int unsigned PW = pend_width(MAX_PENDING);

    logic              acc0;
    logic              acc1;
    logic              vblank_q;
    logic              tick_c;
    coin_state_e       state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              rr_q, rr_d;
    logic [PW-1:0]     pend0_q, pend0_d;
    logic [PW-1:0]     pend1_q, pend1_d;
    logic              coin_out_q;
    logic              busy_q;
    logic              dec0, dec1;
    logic              pref, pref_has, sel;

    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb0 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .raw     (bus.coin_in[0]),
        .rise    (acc0)
    );

    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb1 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .raw     (bus.coin_in[1]),
        .rise    (acc1)
    );

    assign tick_c = bus.vblank & ~vblank_q;

    // State, queues and registered outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fcnt_q     <= '0;
            rr_q       <= 1'b0;
            pend0_q    <= '0;
            pend1_q    <= '0;
            vblank_q   <= 1'b0;
            coin_out_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            rr_q       <= rr_d;
            pend0_q    <= pend0_d;
            pend1_q    <= pend1_d;
            vblank_q   <= bus.vblank;
            coin_out_q <= (state_d == ASSERT);
            busy_q     <= (state_d != IDLE);
        end
    end

    // Next state, arbitration and queue update.
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        rr_d     = rr_q;
        dec0     = 1'b0;
        dec1     = 1'b0;
        pref     = ~rr_q;
        pref_has = pref ? (pend1_q != '0) : (pend0_q != '0);
        sel      = pref_has ? pref : rr_q;

        case (state_q)
            IDLE: begin
                if (tick_c && (pend0_q != '0 || pend1_q != '0)) begin
                    dec0    = ~sel;
                    dec1    = sel;
                    rr_d    = sel;
                    fcnt_d  = '0;
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (tick_c) begin
                    if (fcnt_q == FCNT_W'(PULSE_FRAMES - 1)) begin
                        fcnt_d  = '0;
                        state_d = GAP;
                    end else begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (tick_c) begin
                    if (fcnt_q == FCNT_W'(GAP_FRAMES - 1)) begin
                        fcnt_d  = '0;
                        state_d = IDLE;
                    end else begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                    end
                end
            end
            default: begin
                fcnt_d  = '0;
                state_d = IDLE;
            end
        endcase

        // Accept and grant in the same cycle cancel, so a full queue never drops then.
        pend0_d = pend0_q;
        if (acc0 && !dec0) begin
            if (pend0_q != PW'(MAX_PENDING)) pend0_d = pend0_q + PW'(1);
        end else if (dec0 && !acc0) begin
            pend0_d = pend0_q - PW'(1);
        end

        pend1_d = pend1_q;
        if (acc1 && !dec1) begin
            if (pend1_q != PW'(MAX_PENDING)) pend1_d = pend1_q + PW'(1);
        end else if (dec1 && !acc1) begin
            pend1_d = pend1_q - PW'(1);
        end
    end

    assign bus.coin_out = coin_out_q;
    assign bus.busy     = busy_q;
    assign bus.pending0 = pend0_q;
    assign bus.pending1 = pend1_q;

endmodule

// File: tb/tb_arcade_coin_conditioner.sv
// Randomised bench for arcade_coin_conditioner against an event-level credit/arbitration model.
module tb_arcade_coin_conditioner;
    localparam int DEB    = 4;
    localparam int PULSE  = 3;
    localparam int GAPF   = 3;
    localparam int MAXP   = 7;
    localparam int VB_PER = 100;
    localparam int VB_HI  = 20;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    arcade_coin_conditioner_if #(.PW(3)) bus ();

    arcade_coin_conditioner #(
        .DEB_CYCLES   (DEB),
        .PULSE_FRAMES (PULSE),
        .GAP_FRAMES   (GAPF),
        .MAX_PENDING  (MAXP)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int m_last = 0;
    bit vb_run = 1'b0;
    int vb_phase = 21;

    int rise_cyc[$];
    int rise_ch[$];
    int rise_dly[$];
    int width_q[$];
    int exp_q[$];

    int last_vb_rise = 0;
    int rise_start   = 0;
    logic co_prev = 1'b0;
    logic vb_prev = 1'b0;
    int p0_prev = 0;
    int p1_prev = 0;

    // Frame generator: 100-cycle period, 20 cycles high; stopping forces vblank low.
    initial begin
        bus.vblank = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (vb_run) begin
                vb_phase   = (vb_phase + 1) % VB_PER;
                bus.vblank = (vb_phase < VB_HI);
            end else begin
                vb_phase   = 21;
                bus.vblank = 1'b0;
            end
        end
    end

    // Observer: logs pulse starts, their source channel, frame offset and width.
    always @(negedge clk_sys) begin
        cyc = cyc + 1;
        if (bus.vblank === 1'b1 && vb_prev !== 1'b1) last_vb_rise = cyc;
        if (bus.coin_out === 1'b1 && co_prev !== 1'b1) begin
            rise_cyc.push_back(cyc);
            rise_dly.push_back(cyc - last_vb_rise);
            if (int'(bus.pending0) < p0_prev)      rise_ch.push_back(0);
            else if (int'(bus.pending1) < p1_prev) rise_ch.push_back(1);
            else                                   rise_ch.push_back(2);
            rise_start = cyc;
        end
        if (bus.coin_out !== 1'b1 && co_prev === 1'b1) width_q.push_back(cyc - rise_start);
        co_prev = bus.coin_out;
        vb_prev = bus.vblank;
        p0_prev = int'(bus.pending0);
        p1_prev = int'(bus.pending1);
    end

    initial begin
        #(10 * 90000);
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    // Grant order from the round-robin rule: serve the channel not served last if it has credit.
    function automatic void model_order(input int p0, input int p1);
        int sel;
        exp_q.delete();
        while (p0 + p1 > 0) begin
            if ((m_last == 1 && p0 > 0) || (m_last == 0 && p1 > 0)) sel = 1 - m_last;
            else sel = m_last;
            if (sel == 0) p0--; else p1--;
            exp_q.push_back(sel);
            m_last = sel;
        end
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic clear_log();
        rise_cyc.delete();
        rise_ch.delete();
        rise_dly.delete();
        width_q.delete();
    endtask

    task automatic press(input logic [1:0] m, input int hi);
        @(posedge clk_sys);
        #1 bus.coin_in = bus.coin_in | m;
        repeat (hi) @(posedge clk_sys);
        #1 bus.coin_in = bus.coin_in & ~m;
        repeat (10) @(posedge clk_sys);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        @(negedge clk_sys);
        while (n < budget && !(bus.busy === 1'b0 && bus.pending0 === 3'd0 && bus.pending1 === 3'd0)) begin
            @(negedge clk_sys);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_idle_timeout: waited %0d cycles, limit %0d", nm, n, budget);
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        bus.coin_in = 2'b00;
        vb_run = 1'b1;
        repeat (3) @(negedge clk_sys);
        checks++;
        if (bus.coin_out !== 1'b0 || bus.busy !== 1'b0 || bus.pending0 !== 3'd0 || bus.pending1 !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: coin_out=%b busy=%b p0=%0d p1=%0d, want 0 0 0 0",
                     bus.coin_out, bus.busy, bus.pending0, bus.pending1);
        end
        #2 reset = 1'b0;
        m_last = 0;
        press(2'b01, 12);
        press(2'b10, 12);
        n = 0;
        while (bus.coin_out !== 1'b1 && n < 300) begin @(negedge clk_sys); n++; end
        checks++;
        if (n >= 300) begin errors++; $display("FAIL reset_pulse_start: no pulse within %0d cycles", n); end
        repeat ($urandom_range(1, 100)) @(negedge clk_sys);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.coin_out !== 1'b0 || bus.busy !== 1'b0 || bus.pending0 !== 3'd0 || bus.pending1 !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_assert: coin_out=%b busy=%b p0=%0d p1=%0d, want 0 0 0 0",
                     bus.coin_out, bus.busy, bus.pending0, bus.pending1);
        end
        repeat (3) @(negedge clk_sys);
        #2 reset = 1'b0;
        m_last = 0;
        clear_log();
        press(2'b01, $urandom_range(10, 30));
        wait_idle("reset_restart", 1500);
        checks++;
        if (rise_cyc.size() != 1 || width_q.size() != 1) begin
            errors++;
            $display("FAIL reset_restart_count: pulses=%0d widths=%0d, want 1 1", rise_cyc.size(), width_q.size());
        end else if (width_q[0] != PULSE * VB_PER || rise_dly[0] != 1) begin
            errors++;
            $display("FAIL reset_restart_pulse: width=%0d dly=%0d, want %0d 1", width_q[0], rise_dly[0], PULSE * VB_PER);
        end
        model_order(1, 0);
    endtask

    task automatic test_glitch();
        vb_run = 1'b0;
        repeat (5) @(negedge clk_sys);
        clear_log();
        press(2'b01, $urandom_range(1, DEB - 1));
        repeat (30) @(negedge clk_sys);
        checks++;
        if (bus.pending0 !== 3'd0 || rise_cyc.size() != 0) begin
            errors++;
            $display("FAIL glitch_reject: p0=%0d pulses=%0d, want 0 0", bus.pending0, rise_cyc.size());
        end
        press(2'b01, $urandom_range(10, 30));
        @(negedge clk_sys);
        checks++;
        if (bus.pending0 !== 3'd1) begin
            errors++;
            $display("FAIL glitch_accept: p0=%0d, want 1", bus.pending0);
        end
        model_order(1, 0);
        vb_run = 1'b1;
        wait_idle("glitch", 1500);
        checks++;
        if (rise_cyc.size() != 1 || width_q.size() != 1) begin
            errors++;
            $display("FAIL glitch_count: pulses=%0d widths=%0d, want 1 1", rise_cyc.size(), width_q.size());
        end else if (width_q[0] != PULSE * VB_PER || rise_dly[0] != 1 || rise_ch[0] != exp_q[0]) begin
            errors++;
            $display("FAIL glitch_pulse: width=%0d dly=%0d ch=%0d, want %0d 1 %0d",
                     width_q[0], rise_dly[0], rise_ch[0], PULSE * VB_PER, exp_q[0]);
        end
    endtask

    task automatic test_saturation();
        int n;
        int w;
        int exp_p;
        vb_run = 1'b1;
        clear_log();
        press(2'b10, 12);
        w = 0;
        while (bus.coin_out !== 1'b1 && w < 300) begin @(negedge clk_sys); w++; end
        checks++;
        if (w >= 300) begin errors++; $display("FAIL sat_first_pulse: none within %0d cycles", w); end
        n = $urandom_range(8, 12);
        for (int i = 0; i < n; i++) press(2'b10, 10);
        @(negedge clk_sys);
        exp_p = min_i(n, MAXP);
        checks++;
        if (int'(bus.pending1) != exp_p || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL sat_cap: p1=%0d busy=%b after %0d presses, want %0d 1", bus.pending1, bus.busy, n, exp_p);
        end
        model_order(0, 1 + exp_p);
        wait_idle("sat", (exp_p + 2) * (PULSE + GAPF + 1) * VB_PER);
        checks++;
        if (rise_cyc.size() != 1 + exp_p || width_q.size() != 1 + exp_p) begin
            errors++;
            $display("FAIL sat_pulses: pulses=%0d widths=%0d, want %0d", rise_cyc.size(), width_q.size(), 1 + exp_p);
        end
        foreach (width_q[i]) begin
            checks++;
            if (width_q[i] != PULSE * VB_PER) begin
                errors++;
                $display("FAIL sat_width[%0d]: %0d, want %0d", i, width_q[i], PULSE * VB_PER);
            end
        end
    endtask

    task automatic check_sequence(input string nm);
        checks++;
        if (rise_ch.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: pulses=%0d, want %0d", nm, rise_ch.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (rise_ch[i] != exp_q[i] || width_q[i] != PULSE * VB_PER || rise_dly[i] != 1) begin
                    errors++;
                    $display("FAIL %s_pulse[%0d]: ch=%0d width=%0d dly=%0d, want ch=%0d width=%0d dly=1",
                             nm, i, rise_ch[i], width_q[i], rise_dly[i], exp_q[i], PULSE * VB_PER);
                end
                if (i > 0) begin
                    checks++;
                    if (rise_cyc[i] - rise_cyc[i-1] != (PULSE + GAPF + 1) * VB_PER) begin
                        errors++;
                        $display("FAIL %s_spacing[%0d]: %0d, want %0d", nm, i,
                                 rise_cyc[i] - rise_cyc[i-1], (PULSE + GAPF + 1) * VB_PER);
                    end
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        vb_run = 1'b0;
        repeat (5) @(negedge clk_sys);
        clear_log();
        press(2'b11, $urandom_range(10, 30));
        @(negedge clk_sys);
        checks++;
        if (bus.pending0 !== 3'd1 || bus.pending1 !== 3'd1) begin
            errors++;
            $display("FAIL simul_accept: p0=%0d p1=%0d, want 1 1", bus.pending0, bus.pending1);
        end
        model_order(1, 1);
        vb_run = 1'b1;
        wait_idle("simul", 4 * (PULSE + GAPF + 1) * VB_PER);
        check_sequence("simul");
    endtask

    task automatic test_round_robin();
        int r0;
        int r1;
        int sel;
        vb_run = 1'b0;
        repeat (5) @(negedge clk_sys);
        clear_log();
        r0 = 3;
        r1 = 3;
        while (r0 + r1 > 0) begin
            sel = $urandom_range(0, 2);
            if (sel == 2 && r0 > 0 && r1 > 0) begin press(2'b11, $urandom_range(10, 20)); r0--; r1--; end
            else if ((sel == 0 && r0 > 0) || r1 == 0) begin press(2'b01, $urandom_range(10, 20)); r0--; end
            else begin press(2'b10, $urandom_range(10, 20)); r1--; end
        end
        @(negedge clk_sys);
        checks++;
        if (bus.pending0 !== 3'd3 || bus.pending1 !== 3'd3) begin
            errors++;
            $display("FAIL rr_queue: p0=%0d p1=%0d, want 3 3", bus.pending0, bus.pending1);
        end
        model_order(3, 3);
        vb_run = 1'b1;
        wait_idle("rr", 8 * (PULSE + GAPF + 1) * VB_PER);
        check_sequence("rr");
    endtask

    task automatic test_frozen_vblank();
        vb_run = 1'b0;
        repeat (5) @(negedge clk_sys);
        clear_log();
        press(2'b01, $urandom_range(10, 30));
        press(2'b01, $urandom_range(10, 30));
        repeat (3 * VB_PER) @(negedge clk_sys);
        checks++;
        if (bus.pending0 !== 3'd2 || bus.coin_out !== 1'b0 || rise_cyc.size() != 0) begin
            errors++;
            $display("FAIL frozen_hold: p0=%0d coin_out=%b pulses=%0d, want 2 0 0",
                     bus.pending0, bus.coin_out, rise_cyc.size());
        end
        model_order(2, 0);
        vb_run = 1'b1;
        wait_idle("frozen", 4 * (PULSE + GAPF + 1) * VB_PER);
        check_sequence("frozen");
    endtask

    initial begin
        bus.coin_in = 2'b00;
        test_reset();
        test_glitch();
        test_saturation();
        test_simultaneous();
        test_round_robin();
        test_frozen_vblank();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
